// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: UART command decoder that issues single 32-bit bus reads/writes
// and returns the result over UART (8N1).
// Optional feature macro: UART_DBG_CSUM_EN adds a trailing XOR checksum byte per frame.
module uart_dbg_bridge #(
   parameter int CLK_DIV      = 440,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_uart_rx,
   output logic        o_uart_tx,
   output logic        o_mem_we,
   output logic        o_mem_re,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   output logic        o_busy,
   output logic        o_frame_err
);
   localparam int CW       = $clog2(CLK_DIV);
   localparam int TO_LIMIT = TIMEOUT_BITS * CLK_DIV;
   localparam int TW       = $clog2(TO_LIMIT);
   localparam logic [CW-1:0] HALF_BIT  = CW'(CLK_DIV / 2);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);
   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK    = 8'h06;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_BUS, S_RDWAIT, S_RESP
`ifdef UART_DBG_CSUM_EN
      , S_CSUM
`endif
   } state_t;

   state_t r_state, w_nextState;
   logic [1:0] r_rxSync;
   logic r_rxPrev, r_rxActive, r_rxValid, r_rxErr;
   logic [CW-1:0] r_rxCnt, r_txCnt;
   logic [3:0] r_rxBit, r_txBit;
   logic [7:0] r_rxShift, r_rxByte, r_txData, r_csum, w_txData;
   logic r_txActive, r_txLine, r_isWrite, r_nak, r_frameErr;
   logic [2:0] r_byteIdx, r_respIdx;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [TW-1:0] r_toCnt;
   logic w_rxLine, w_txLast, w_txLoad, w_memWe, w_memRe, w_timeout, w_inFrame, w_receiving;
   logic [2:0] w_respLen;
   state_t w_afterPayload;

   assign w_rxLine    = r_rxSync[1];
   assign w_txLast    = r_txActive && (r_txCnt == BAUD_LAST) && (r_txBit == 4'd9);
   assign w_respLen   = (r_isWrite || r_nak) ? 3'd1 : 3'd4;
`ifdef UART_DBG_CSUM_EN
   assign w_inFrame      = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CSUM);
   assign w_afterPayload = S_CSUM;
`else
   assign w_inFrame      = (r_state == S_ADDR) || (r_state == S_DATA);
   assign w_afterPayload = S_BUS;
`endif
   assign w_receiving = w_inFrame || (r_state == S_IDLE);
   assign o_uart_tx   = r_txLine;
   assign o_mem_we    = w_memWe;
   assign o_mem_re    = w_memRe;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_busy      = (r_state != S_IDLE);
   assign o_frame_err = r_frameErr;

   // RX: synchronise the line, qualify the start bit at mid-bit, then shift in data and check stop.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_rxSync <= 2'b11;
         r_rxPrev <= 1'b1;
         r_rxActive <= 1'b0;
         r_rxCnt <= '0;
         r_rxBit <= 4'd0;
         r_rxShift <= 8'h00;
         r_rxByte <= 8'h00;
         r_rxValid <= 1'b0;
         r_rxErr <= 1'b0;
      end else begin
         r_rxSync <= {r_rxSync[0], i_uart_rx};
         r_rxPrev <= w_rxLine;
         r_rxValid <= 1'b0;
         r_rxErr <= 1'b0;
         if (!r_rxActive) begin
            if (r_rxPrev && !w_rxLine) begin
               r_rxActive <= 1'b1;
               r_rxCnt <= '0;
               r_rxBit <= 4'd0;
            end
         end else if (r_rxBit == 4'd0) begin
            if (r_rxCnt == HALF_BIT) begin
               r_rxCnt <= '0;
               if (w_rxLine) r_rxActive <= 1'b0;
               else          r_rxBit <= 4'd1;
            end else begin
               r_rxCnt <= r_rxCnt + 1'b1;
            end
         end else if (r_rxCnt == BAUD_LAST) begin
            r_rxCnt <= '0;
            if (r_rxBit <= 4'd8) begin
               r_rxShift <= {w_rxLine, r_rxShift[7:1]};
               r_rxBit <= r_rxBit + 4'd1;
            end else begin
               r_rxActive <= 1'b0;
               if (w_rxLine) begin
                  r_rxValid <= 1'b1;
                  r_rxByte <= r_rxShift;
               end else begin
                  r_rxErr <= 1'b1;
               end
            end
         end else begin
            r_rxCnt <= r_rxCnt + 1'b1;
         end
      end
   end

   // TX: a load starts a new byte immediately, even on the last cycle of the previous stop bit.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_txActive <= 1'b0;
         r_txLine <= 1'b1;
         r_txData <= 8'h00;
         r_txCnt <= '0;
         r_txBit <= 4'd0;
      end else if (w_txLoad) begin
         r_txActive <= 1'b1;
         r_txLine <= 1'b0;
         r_txData <= w_txData;
         r_txCnt <= '0;
         r_txBit <= 4'd0;
      end else if (r_txActive) begin
         if (r_txCnt == BAUD_LAST) begin
            r_txCnt <= '0;
            if (r_txBit == 4'd9) begin
               r_txActive <= 1'b0;
               r_txLine <= 1'b1;
            end else begin
               r_txBit <= r_txBit + 4'd1;
               r_txLine <= (r_txBit < 4'd8) ? r_txData[r_txBit[2:0]] : 1'b1;
            end
         end else begin
            r_txCnt <= r_txCnt + 1'b1;
         end
      end
   end

   // Frame FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_rst) r_state <= S_IDLE;
      else        r_state <= w_nextState;
   end

   // Next-state, bus strobes and response byte selection.
   always_comb begin
      w_nextState = r_state;
      w_memWe = 1'b0;
      w_memRe = 1'b0;
      w_txLoad = 1'b0;
      w_txData = 8'h00;
      w_timeout = w_inFrame && !r_rxValid && (r_toCnt == TO_LAST);
      case (r_state)
         S_IDLE: begin
            if (r_rxValid && (r_rxByte == CMD_WR || r_rxByte == CMD_RD)) w_nextState = S_ADDR;
         end
         S_ADDR: begin
            if (w_timeout || r_rxErr) w_nextState = S_IDLE;
            else if (r_rxValid && r_byteIdx == 3'd3) w_nextState = r_isWrite ? S_DATA : w_afterPayload;
         end
         S_DATA: begin
            if (w_timeout || r_rxErr) w_nextState = S_IDLE;
            else if (r_rxValid && r_byteIdx == 3'd3) w_nextState = w_afterPayload;
         end
`ifdef UART_DBG_CSUM_EN
         S_CSUM: begin
            if (w_timeout || r_rxErr) begin
               w_nextState = S_IDLE;
            end else if (r_rxValid) begin
               if (r_rxByte == r_csum) begin
                  w_nextState = S_BUS;
               end else begin
                  w_nextState = S_RESP;
                  w_txLoad = 1'b1;
                  w_txData = 8'h15;
               end
            end
         end
`endif
         S_BUS: begin
            w_memWe = r_isWrite;
            w_memRe = !r_isWrite;
            if (r_isWrite) begin
               w_txLoad = 1'b1;
               w_txData = ACK;
               w_nextState = S_RESP;
            end else begin
               w_nextState = S_RDWAIT;
            end
         end
         S_RDWAIT: begin
            w_txLoad = 1'b1;
            w_txData = i_mem_rdata[31:24];
            w_nextState = S_RESP;
         end
         S_RESP: begin
            if (w_txLast) begin
               if (r_respIdx < w_respLen) begin
                  w_txLoad = 1'b1;
                  case (r_respIdx[1:0])
                     2'd1:    w_txData = r_rdata[23:16];
                     2'd2:    w_txData = r_rdata[15:8];
                     default: w_txData = r_rdata[7:0];
                  endcase
               end else begin
                  w_nextState = S_IDLE;
               end
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Frame datapath: capture address/data, running checksum, read data and response progress.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_isWrite <= 1'b0;
         r_nak <= 1'b0;
         r_byteIdx <= 3'd0;
         r_respIdx <= 3'd0;
         r_csum <= 8'h00;
         r_addr <= 32'h0;
         r_wdata <= 32'h0;
         r_rdata <= 32'h0;
         r_toCnt <= '0;
         r_frameErr <= 1'b0;
      end else begin
         r_frameErr <= w_timeout || (w_receiving && r_rxErr);
         r_toCnt <= (w_inFrame && !r_rxValid) ? r_toCnt + 1'b1 : '0;
         if (w_txLoad) r_respIdx <= r_respIdx + 3'd1;
         case (r_state)
            S_IDLE: begin
               if (w_nextState == S_ADDR) begin
                  r_isWrite <= (r_rxByte == CMD_WR);
                  r_csum <= r_rxByte;
                  r_nak <= 1'b0;
                  r_byteIdx <= 3'd0;
                  r_respIdx <= 3'd0;
               end
            end
            S_ADDR, S_DATA: begin
               if (r_rxValid) begin
                  if (r_state == S_ADDR) r_addr <= {r_addr[23:0], r_rxByte};
                  else                   r_wdata <= {r_wdata[23:0], r_rxByte};
                  r_csum <= r_csum ^ r_rxByte;
                  r_byteIdx <= (r_byteIdx == 3'd3) ? 3'd0 : r_byteIdx + 3'd1;
               end
            end
`ifdef UART_DBG_CSUM_EN
            S_CSUM: begin
               if (r_rxValid && r_rxByte != r_csum) r_nak <= 1'b1;
            end
`endif
            S_RDWAIT: r_rdata <= i_mem_rdata;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb_uart_dbg_bridge: directed bench for uart_dbg_bridge with a UART BFM and a
// 1-cycle-latency bus memory model. Runs with CLK_DIV=16, TIMEOUT_BITS=64.
module tb_uart_dbg_bridge;
   localparam int CLK_DIV = 16;
   localparam int TIMEOUT_BITS = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx = 1'b1;
   logic tx, memWe, memRe, busy, frameErr;
   logic [31:0] memAddr, memWdata;
   logic [31:0] rdata = 32'h0;

   int checks = 0;
   int errors = 0;
   int weCount = 0, reCount = 0, errCount = 0, busyRise = 0, txFalls = 0, txCount = 0;
   logic [31:0] lastAddr = 32'h0, lastWdata = 32'h0, lastReAddr = 32'h0;
   logic [7:0] txBytes [0:63];
   logic [31:0] mem [logic [31:0]];
   logic preloadEn = 1'b0;
   logic [31:0] preAddr = 32'h0, preData = 32'h0;
   logic prevBusy = 1'b0;
   logic [7:0] frameQ [$];
   int we0, re0, e0, tx0, b0, f0;

   uart_dbg_bridge #(.CLK_DIV(CLK_DIV), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
      .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .o_uart_tx(tx),
      .o_mem_we(memWe), .o_mem_re(memRe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
      .i_mem_rdata(rdata), .o_busy(busy), .o_frame_err(frameErr)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Bus memory model: writes land at the edge, read data appears the cycle after mem_re.
   always @(posedge clk) begin
      if (preloadEn) mem[preAddr] = preData;
      if (memWe) mem[memAddr] = memWdata;
      if (memRe) rdata <= mem.exists(memAddr) ? mem[memAddr] : 32'hBAD0BAD0;
   end

   // Event counters sampled mid-cycle.
   always @(negedge clk) begin
      if (memWe) begin weCount++; lastAddr = memAddr; lastWdata = memWdata; end
      if (memRe) begin reCount++; lastReAddr = memAddr; end
      if (frameErr) errCount++;
      if (busy && !prevBusy) busyRise++;
      prevBusy = busy;
   end

   // Count every falling edge on the tx line.
   always @(negedge tx) txFalls++;

   // UART receive BFM for the DUT's tx; bytes interrupted by reset are discarded.
   initial begin : txMon
      forever begin
         logic [7:0] b;
         logic ok;
         @(negedge tx);
         ok = 1'b1;
         b = 8'h00;
         repeat (CLK_DIV / 2) begin @(negedge clk); if (!rst) ok = 1'b0; end
         if (tx !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) begin @(negedge clk); if (!rst) ok = 1'b0; end
            b[i] = tx;
         end
         repeat (CLK_DIV) begin @(negedge clk); if (!rst) ok = 1'b0; end
         if (tx !== 1'b1) ok = 1'b0;
         if (ok && txCount < 64) begin
            txBytes[txCount] = b;
            txCount++;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input logic badStop);
      @(negedge clk);
      rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rx = badStop ? 1'b0 : 1'b1;
      repeat (CLK_DIV) @(negedge clk);
      rx = 1'b1;
   endtask

   // Send frameQ, followed by its XOR checksum when the checksum build is selected.
   task automatic applyStimulus();
      logic [7:0] cs;
      cs = 8'h00;
      foreach (frameQ[i]) begin
         sendByte(frameQ[i], 1'b0);
         cs = cs ^ frameQ[i];
      end
`ifdef UART_DBG_CSUM_EN
      sendByte(cs, 1'b0);
`endif
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
      checkOutput(tag, 32'(busy), 32'd0);
   endtask

   task automatic waitTxCount(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (txCount < target && n < budget) begin @(negedge clk); n++; end
      checkOutput(tag, 32'(txCount >= target), 32'd1);
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      preAddr = a; preData = d; preloadEn = 1'b1;
      @(negedge clk);
      preloadEn = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      repeat (5) @(negedge clk);
      checkOutput("rst_tx", 32'(tx), 32'd1);
      checkOutput("rst_we", 32'(memWe), 32'd0);
      checkOutput("rst_re", 32'(memRe), 32'd0);
      checkOutput("rst_addr", memAddr, 32'h0);
      checkOutput("rst_wdata", memWdata, 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ferr", 32'(frameErr), 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] test 1: write");
      we0 = weCount; re0 = reCount; tx0 = txCount;
      frameQ = {8'h57, 8'h10, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      applyStimulus();
      waitIdle("t1_idle", 3000);
      checkOutput("t1_we_cnt", weCount - we0, 32'd1);
      checkOutput("t1_re_cnt", reCount - re0, 32'd0);
      checkOutput("t1_addr", lastAddr, 32'h10000004);
      checkOutput("t1_wdata", lastWdata, 32'hDEADBEEF);
      checkOutput("t1_tx_cnt", txCount - tx0, 32'd1);
      checkOutput("t1_tx_ack", {24'h0, txBytes[tx0]}, 32'h06);

      $display("[TB] test 2: read");
      preload(32'h20, 32'h12345678);
      we0 = weCount; re0 = reCount; tx0 = txCount;
      frameQ = {8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
      applyStimulus();
      waitIdle("t2_idle", 3000);
      checkOutput("t2_re_cnt", reCount - re0, 32'd1);
      checkOutput("t2_we_cnt", weCount - we0, 32'd0);
      checkOutput("t2_addr", lastReAddr, 32'h20);
      checkOutput("t2_tx_cnt", txCount - tx0, 32'd4);
      checkOutput("t2_tx0", {24'h0, txBytes[tx0]}, 32'h12);
      checkOutput("t2_tx1", {24'h0, txBytes[tx0 + 1]}, 32'h34);
      checkOutput("t2_tx2", {24'h0, txBytes[tx0 + 2]}, 32'h56);
      checkOutput("t2_tx3", {24'h0, txBytes[tx0 + 3]}, 32'h78);

      $display("[TB] test 3: bad stop bit");
      we0 = weCount; re0 = reCount; e0 = errCount; tx0 = txCount;
      sendByte(8'h57, 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("t3_ferr_cnt", errCount - e0, 32'd1);
      checkOutput("t3_no_bus", (weCount - we0) + (reCount - re0), 32'd0);
      checkOutput("t3_busy", 32'(busy), 32'd0);
      frameQ = {8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
      applyStimulus();
      waitIdle("t3_idle", 3000);
      checkOutput("t3_re_cnt", reCount - re0, 32'd1);
      checkOutput("t3_tx_cnt", txCount - tx0, 32'd4);
      checkOutput("t3_tx0", {24'h0, txBytes[tx0]}, 32'h12);
      checkOutput("t3_tx3", {24'h0, txBytes[tx0 + 3]}, 32'h78);

      $display("[TB] test 4: garbage byte and glitch");
      e0 = errCount; tx0 = txCount; b0 = busyRise;
      sendByte(8'h00, 1'b0);
      repeat (10) @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (300) @(negedge clk);
      checkOutput("t4_tx_cnt", txCount - tx0, 32'd0);
      checkOutput("t4_ferr_cnt", errCount - e0, 32'd0);
      checkOutput("t4_busy_rise", busyRise - b0, 32'd0);

      $display("[TB] test 5: inter-byte timeout");
      we0 = weCount; e0 = errCount; tx0 = txCount;
      sendByte(8'h57, 1'b0);
      sendByte(8'h10, 1'b0);
      repeat (500) @(negedge clk);
      checkOutput("t5_busy_mid", 32'(busy), 32'd1);
      checkOutput("t5_ferr_early", errCount - e0, 32'd0);
      repeat (700) @(negedge clk);
      checkOutput("t5_ferr_cnt", errCount - e0, 32'd1);
      checkOutput("t5_busy_after", 32'(busy), 32'd0);
      checkOutput("t5_no_we", weCount - we0, 32'd0);
      checkOutput("t5_no_tx", txCount - tx0, 32'd0);
      frameQ = {8'h57, 8'h00, 8'h00, 8'h00, 8'h40, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
      applyStimulus();
      waitIdle("t5_idle", 3000);
      checkOutput("t5_we_cnt", weCount - we0, 32'd1);
      checkOutput("t5_addr", lastAddr, 32'h40);
      checkOutput("t5_wdata", lastWdata, 32'hCAFEBABE);
      checkOutput("t5_tx_ack", {24'h0, txBytes[tx0]}, 32'h06);

      $display("[TB] test 6: reset during response");
      tx0 = txCount;
      frameQ = {8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
      applyStimulus();
      waitTxCount("t6_first_byte", tx0 + 1, 600);
      repeat (40) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("t6_rst_tx", 32'(tx), 32'd1);
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      f0 = txFalls;
      repeat (400) @(negedge clk);
      checkOutput("t6_tx_quiet", txFalls - f0, 32'd0);
      checkOutput("t6_tx_idle", 32'(tx), 32'd1);
      checkOutput("t6_busy_after", 32'(busy), 32'd0);
      checkOutput("t6_tx_cnt", txCount - tx0, 32'd1);

`ifdef UART_DBG_CSUM_EN
      $display("[TB] test 7: checksum mismatch");
      re0 = reCount; e0 = errCount; tx0 = txCount;
      sendByte(8'h52, 1'b0);
      sendByte(8'h00, 1'b0);
      sendByte(8'h00, 1'b0);
      sendByte(8'h00, 1'b0);
      sendByte(8'h20, 1'b0);
      sendByte(8'h00, 1'b0);
      waitIdle("t7_idle", 3000);
      checkOutput("t7_no_re", reCount - re0, 32'd0);
      checkOutput("t7_no_ferr", errCount - e0, 32'd0);
      checkOutput("t7_tx_cnt", txCount - tx0, 32'd1);
      checkOutput("t7_tx_nak", {24'h0, txBytes[tx0]}, 32'h15);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
